// File: rtl/qed_pkg.sv
// Shared definitions for the QED fetch scheduler: filler instruction, bundle width, FSM states.
package qed_pkg;
    localparam logic [31:0] QED_NOP  = 32'h0000_0013;
    localparam int          BUNDLE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/qed_sync_fifo.sv
// Synchronous FIFO with a two-word peek port and a 0..2 pop count; no fall-through.
import qed_pkg::*;

module qed_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [1:0]               pop_cnt_i,
    output logic [W-1:0]             peek0_o,
    output logic [W-1:0]             peek1_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;

    assign full_o  = (r_level == (AW+1)'(DEPTH));
    assign w_push  = push_i && !full_o;
    assign peek0_o = r_mem[r_rd_ptr];
    assign peek1_o = r_mem[r_rd_ptr + AW'(1)];
    assign level_o = r_level;

    // Storage write; contents need no reset because the level gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + AW'(pop_cnt_i);
            r_level  <= r_level + (AW+1)'(w_push) - (AW+1)'(pop_cnt_i);
        end
    end
endmodule

// File: rtl/qed_fetch_sched.sv
// Feeds the biriscv fetch port from the QED instruction stream: one outstanding fetch,
// 64-bit bundles placed by PC half, misalignment errors and starvation accounting.
import qed_pkg::*;

module qed_fetch_sched #(
    parameter int          DEPTH   = 4,
    parameter bit          PAIR_EN = 1'b1,
    parameter logic [31:0] NOP     = QED_NOP
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mem_i_rd_i,
    input  logic                   mem_i_flush_i,
    input  logic                   mem_i_invalidate_i,
    input  logic [31:0]            mem_i_pc_i,
    output logic                   mem_i_accept_o,
    output logic                   mem_i_valid_o,
    output logic                   mem_i_error_o,
    output logic [BUNDLE_W-1:0]    mem_i_inst_o,
    input  logic                   src_valid_i,
    input  logic [31:0]            src_inst_i,
    output logic                   src_ready_o,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic [15:0]            starve_cnt_o
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    fetch_state_e        r_state;
    logic [2:0]          r_pc_lo;
    logic                r_valid;
    logic                r_error;
    logic [BUNDLE_W-1:0] r_inst;
    logic [15:0]         r_starve;

    logic                w_cancel;
    logic                w_full;
    logic [31:0]         w_peek0;
    logic [31:0]         w_peek1;
    logic [LVL_W-1:0]    w_level;
    logic [1:0]          w_pop_cnt;
    logic [BUNDLE_W-1:0] w_bundle;

    assign w_cancel = mem_i_flush_i || mem_i_invalidate_i;

    qed_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (src_valid_i && src_ready_o),
        .wdata_i   (src_inst_i),
        .pop_cnt_i (w_pop_cnt),
        .peek0_o   (w_peek0),
        .peek1_o   (w_peek1),
        .level_o   (w_level),
        .full_o    (w_full)
    );

    // Bundle placement and pop count for the word(s) consumed when WAIT resolves.
    always_comb begin
        w_pop_cnt = 2'd0;
        w_bundle  = {NOP, NOP};
        if (r_state == ST_WAIT && !w_cancel && r_pc_lo[1:0] == 2'b00 && w_level != '0) begin
            if (r_pc_lo[2]) begin
                w_bundle  = {w_peek0, NOP};
                w_pop_cnt = 2'd1;
            end else if (PAIR_EN && w_level >= LVL_W'(2)) begin
                w_bundle  = {w_peek1, w_peek0};
                w_pop_cnt = 2'd2;
            end else begin
                w_bundle  = {NOP, w_peek0};
                w_pop_cnt = 2'd1;
            end
        end else begin
            w_pop_cnt = 2'd0;
        end
    end

    // Fetch FSM with registered bundle, valid, error and starvation counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_pc_lo  <= 3'd0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_inst   <= {NOP, NOP};
            r_starve <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    r_error <= 1'b0;
                    if (mem_i_rd_i && !w_cancel) begin
                        r_pc_lo <= mem_i_pc_i[2:0];
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_cancel) begin
                        r_state <= ST_IDLE;
                    end else if (r_pc_lo[1:0] != 2'b00) begin
                        r_inst  <= {NOP, NOP};
                        r_error <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (w_level != '0) begin
                        r_inst  <= w_bundle;
                        r_error <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (r_starve != 16'hFFFF) begin
                        r_starve <= r_starve + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_valid <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A cancel landing in RESP drops the response; the popped words stay consumed.
    assign mem_i_accept_o = rst_ni && (r_state == ST_IDLE);
    assign mem_i_valid_o  = r_valid && !w_cancel;
    assign mem_i_error_o  = r_error;
    assign mem_i_inst_o   = r_inst;
    assign src_ready_o    = rst_ni && !w_full;
    assign fifo_level_o   = w_level;
    assign starve_cnt_o   = r_starve;
endmodule
